axis_channel_router: RTL and testbench
======================================

# axis_channel_router

Parametrised PS-to-PL stream router that delivers one AXI-Stream input to one channel, or in broadcast mode to several of N_CH channels. Channel selection is packet-aware: it is locked for the duration of a packet and changes only at tlast boundaries. A single-entry output register decouples the input from per-channel backpressure. It sits between the ps_to_pl stream and the per-channel waveform/memory loaders.

## Interface
- DATA_W, 256: tdata width in bits.
- N_CH, 16: number of output channels (2..32).
- BCAST_EN, 1: 1 = a multi-hot select broadcasts; 0 = a multi-hot select is illegal.
- clk  in  1  single clock for all logic.
- rstn  in  1  reset; synchronous, active-low.
- channel_select  in  N_CH  target channel mask from PS register space; quasi-static.
- s_axis_tdata  in  DATA_W  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tlast  in  1  input end-of-packet.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  N_CH*DATA_W  channel i data at bits [i*DATA_W +: DATA_W].
- m_axis_tvalid  out  N_CH  per-channel valid.
- m_axis_tlast  out  N_CH  per-channel last.
- m_axis_tready  in  N_CH  per-channel ready.
- busy  out  1  high while in PKT state or while any output beat is pending.
- sel_err  out  1  high while the registered select is illegal (multi-hot with BCAST_EN=0).
- pkt_count  out  32  packets fully delivered; wraps at 2^32.

## Operation
- sel_q <= channel_select every cycle while in IDLE. It is frozen in PKT.
- FSM has two states:
  - IDLE -> PKT on an accepted input beat with tlast=0.
  - PKT -> IDLE on an accepted input beat with tlast=1.
  - A single-beat packet (tlast=1 accepted in IDLE) stays in IDLE.
- The select is legal when sel_q != 0, and additionally popcount(sel_q) == 1 if BCAST_EN=0.
- An illegal or zero select forces s_axis_tready=0. The input stalls; no data is ever dropped. If the select becomes illegal in PKT, the stall holds until reset. This cannot happen from channel_select because sel_q is frozen in PKT.
- Output register holds out_data, out_last and pend[N_CH].
  - m_axis_tvalid = pend. m_axis_tlast[i] = out_last & pend[i].
  - m_axis_tdata[i] = out_data when pend[i], else 0.
- Channel i completes when pend[i] & m_axis_tready[i]. That cycle clears pend[i].
- A beat is delivered when all its pend bits are cleared. Channels drain independently; in broadcast, a slow channel holds back the next beat.
- s_axis_tready = legal & ((pend & ~m_axis_tready) == 0). This is the only combinational path from m_axis_tready to s_axis_tready. It allows full throughput with one channel at 1 beat/cycle.
- On input accept: out_data <= tdata, out_last <= tlast, pend <= sel_q.
- pkt_count increments on the cycle the last pend bit of a beat with out_last=1 clears.
- Reset values:
  - Outputs: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, sel_err=0, pkt_count=0.
  - Internal: state=IDLE, sel_q=0, pend=0.
- Reset mid-packet abandons the packet. No tlast is generated for it.

## Timing
- Select latency: a channel_select write is visible in sel_q 1 cycle later if in IDLE. Otherwise it takes effect on the cycle after the tlast accept.
- Data latency: input accept at cycle t -> m_axis_tvalid high at t+1.
- Simultaneous tlast accept and channel_select change: the new select is sampled on the next IDLE cycle.
- Simultaneous drain of the last pend bit and a new input accept: pend reloads in the same cycle and the new beat wins.
- The counter wraps 0xFFFFFFFF -> 0 silently.

## Structure
- Package axis_router_pkg holds:
  - the state enum (IDLE, PKT);
  - default constants DATA_W_DEF=256 and N_CH_DEF=16;
  - a function onehot_legal(mask, bcast_en).
- Sub-module axis_bcast_stage holds out_data, out_last, the pend mask and the drain/accept logic, parameterised on DATA_W and N_CH. The top level holds the FSM, sel_q, the legality check and pkt_count.

## Test plan
- Single channel, sel=0x0004: a 4-beat packet into always-ready ch2 -> 4 beats on ch2 only, tlast on beat 4, pkt_count=1, zero bubbles.
- Mid-packet select change: sel switches 0x0004->0x0010 after beat 2 of a 4-beat packet -> all 4 beats on ch2; the next packet goes to ch4.
- Broadcast, sel=0x0003, ch1 ready held low for 3 cycles -> ch0 takes the beat at t+1, ch1 at t+4. s_axis_tready stays low until t+4. pkt_count increments once.
- BCAST_EN=0 with sel=0x0003 -> sel_err=1, s_axis_tready=0, no m_axis_tvalid. Setting sel=0x0001 clears sel_err and traffic resumes.
- sel=0 with tvalid high -> s_axis_tready=0 indefinitely, no output, busy=0.
- rstn low for 1 cycle after beat 2 of 5 -> all outputs at reset values. The next packet routes with the freshly sampled select. pkt_count restarts at 0.

Source files
------------

// File: rtl/axis_router_pkg.sv
// axis_router_pkg
//   Shared types and helpers for the AXI-Stream channel router.
//   - state_e       : packet-tracking FSM states (IDLE, PKT)
//   - DATA_W_DEF    : default tdata width
//   - N_CH_DEF      : default channel count
//   - MAX_CH        : widest channel mask the helpers accept
//   - onehot_legal  : select-mask legality check (non-zero, one-hot unless broadcasting)
package axis_router_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 256;
  localparam int N_CH_DEF   = 16;
  localparam int MAX_CH     = 32;

  // A mask is legal when it names at least one channel; without broadcast
  // it must name exactly one. mask & (mask - 1) clears the lowest set bit,
  // so it is zero exactly when at most one bit is set.
  function automatic logic onehot_legal(input logic [MAX_CH-1:0] mask,
                                        input logic              bcast_en);
    logic w_nonzero;
    logic w_single;
    w_nonzero = (mask != 32'd0);
    w_single  = ((mask & (mask - 32'd1)) == 32'd0);
    if (!w_nonzero) begin
      return 1'b0;
    end else if (bcast_en) begin
      return 1'b1;
    end else begin
      return w_single;
    end
  endfunction

endpackage

// File: rtl/axis_bcast_stage.sv
// axis_bcast_stage
//   Single-entry output register that fans one accepted beat out to a set of
//   channels and lets each channel drain independently.
//   Ports:
//     clk, rstn     : clock, synchronous active-low reset
//     i_accept      : input beat accepted this cycle (load the register)
//     i_data/i_last : beat payload and end-of-packet flag
//     i_sel         : channel mask the beat is delivered to
//     i_ready       : per-channel ready
//     o_tdata       : channel i data at [i*DATA_W +: DATA_W], zero when idle
//     o_tvalid      : per-channel valid (the pending mask)
//     o_tlast       : per-channel last
//     o_pend_any    : some channel still owes a handshake
//     o_stall       : some pending channel is not ready this cycle
//     o_beat_done   : the remaining pending channels all complete this cycle
//     o_beat_last   : the held beat carries tlast
module axis_bcast_stage
  import axis_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_CH   = N_CH_DEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_accept,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_last,
  input  logic [N_CH-1:0]        i_sel,
  input  logic [N_CH-1:0]        i_ready,
  output logic [N_CH*DATA_W-1:0] o_tdata,
  output logic [N_CH-1:0]        o_tvalid,
  output logic [N_CH-1:0]        o_tlast,
  output logic                   o_pend_any,
  output logic                   o_stall,
  output logic                   o_beat_done,
  output logic                   o_beat_last
);

  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic [N_CH-1:0]   r_pend;

  // Drain status of the held beat.
  always_comb begin
    o_pend_any  = |r_pend;
    o_stall     = |(r_pend & ~i_ready);
    o_beat_done = (|r_pend) & ~(|(r_pend & ~i_ready));
    o_beat_last = r_last;
  end

  // Output register: a new beat reloads the whole mask (it can only be
  // accepted once every outstanding channel completes this cycle), otherwise
  // each channel that handshakes drops out of the pending mask.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_data <= '0;
      r_last <= 1'b0;
      r_pend <= '0;
    end else if (i_accept) begin
      r_data <= i_data;
      r_last <= i_last;
      r_pend <= i_sel;
    end else begin
      r_pend <= r_pend & ~i_ready;
    end
  end

  // Per-channel valid/last are the pending mask.
  always_comb begin
    o_tvalid = r_pend;
    o_tlast  = {N_CH{r_last}} & r_pend;
  end

  // Data is presented only to channels that still owe a handshake.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch_data
    assign o_tdata[gi*DATA_W +: DATA_W] = r_pend[gi] ? r_data : {DATA_W{1'b0}};
  end

endmodule

// File: rtl/axis_channel_router.sv
// axis_channel_router
//   Routes one AXI-Stream input to one (or, with broadcast, several) of N_CH
//   output channels. The channel mask is sampled while idle and locked for
//   the whole packet; it can only change at a tlast boundary.
//   Ports:
//     clk, rstn       : clock, synchronous active-low reset
//     channel_select  : requested channel mask (quasi-static)
//     s_axis_*        : input stream
//     m_axis_*        : per-channel output streams (tdata packed per channel)
//     busy            : packet in progress or a beat still pending
//     sel_err         : sampled mask is multi-hot while broadcast is disabled
//     pkt_count       : packets fully delivered, wraps at 2^32
module axis_channel_router
  import axis_router_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int N_CH     = N_CH_DEF,
  parameter int BCAST_EN = 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [N_CH-1:0]        channel_select,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  output logic                   s_axis_tready,
  output logic [N_CH*DATA_W-1:0] m_axis_tdata,
  output logic [N_CH-1:0]        m_axis_tvalid,
  output logic [N_CH-1:0]        m_axis_tlast,
  input  logic [N_CH-1:0]        m_axis_tready,
  output logic                   busy,
  output logic                   sel_err,
  output logic [31:0]            pkt_count
);

  localparam logic LP_BCAST = (BCAST_EN != 0);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [N_CH-1:0] r_sel_q;
  logic [31:0]     r_pkt_count;

  logic [MAX_CH-1:0] w_sel_ext;
  logic              w_legal;
  logic              w_accept;
  logic              w_sel_open;
  logic              w_pend_any;
  logic              w_stall;
  logic              w_beat_done;
  logic              w_beat_last;

  // Widen the sampled mask to the helper's fixed width.
  always_comb begin
    w_sel_ext             = '0;
    w_sel_ext[N_CH-1:0]   = r_sel_q;
  end

  // Legality of the sampled mask and the input handshake. Backpressure from
  // a pending-but-not-ready channel is the only path from m_axis_tready to
  // s_axis_tready, which keeps one always-ready channel at full rate.
  always_comb begin
    w_legal       = onehot_legal(w_sel_ext, LP_BCAST);
    sel_err       = (r_sel_q != '0) & ~onehot_legal(w_sel_ext, LP_BCAST);
    s_axis_tready = w_legal & ~w_stall;
    w_accept      = s_axis_tvalid & s_axis_tready;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a non-last beat opens a packet, a last beat closes it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept && !s_axis_tlast) begin
          w_state_nxt = PKT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      PKT: begin
        if (w_accept && s_axis_tlast) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = PKT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs. The select keeps tracking channel_select while idle, but
  // not on the cycle a packet's first beat is taken: that beat was routed
  // with the current mask, so the rest of the packet must follow it.
  always_comb begin
    w_sel_open = 1'b0;
    busy       = w_pend_any;
    case (r_state)
      IDLE: begin
        w_sel_open = ~(w_accept & ~s_axis_tlast);
        busy       = w_pend_any;
      end
      PKT: begin
        w_sel_open = 1'b0;
        busy       = 1'b1;
      end
      default: begin
        w_sel_open = 1'b0;
        busy       = w_pend_any;
      end
    endcase
  end

  // Sampled channel mask.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sel_q <= '0;
    end else if (w_sel_open) begin
      r_sel_q <= channel_select;
    end else begin
      r_sel_q <= r_sel_q;
    end
  end

  // Delivered-packet counter: counts when the final pending channel of a
  // tlast beat completes; wraps silently.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_pkt_count <= 32'd0;
    end else if (w_beat_done && w_beat_last) begin
      r_pkt_count <= r_pkt_count + 32'd1;
    end else begin
      r_pkt_count <= r_pkt_count;
    end
  end

  assign pkt_count = r_pkt_count;

  axis_bcast_stage #(
    .DATA_W (DATA_W),
    .N_CH   (N_CH)
  ) u_stage (
    .clk         (clk),
    .rstn        (rstn),
    .i_accept    (w_accept),
    .i_data      (s_axis_tdata),
    .i_last      (s_axis_tlast),
    .i_sel       (r_sel_q),
    .i_ready     (m_axis_tready),
    .o_tdata     (m_axis_tdata),
    .o_tvalid    (m_axis_tvalid),
    .o_tlast     (m_axis_tlast),
    .o_pend_any  (w_pend_any),
    .o_stall     (w_stall),
    .o_beat_done (w_beat_done),
    .o_beat_last (w_beat_last)
  );

endmodule

// File: tb/tb_axis_channel_router.sv
// tb_axis_channel_router
//   Directed bench: one broadcast-enabled router and one broadcast-disabled
//   router, narrow data for readability, expected values written by hand.
module tb_axis_channel_router;

  localparam int DW = 32;
  localparam int NC = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;

  // broadcast-enabled instance
  logic [NC-1:0]    sel;
  logic [DW-1:0]    s_tdata;
  logic             s_tvalid;
  logic             s_tlast;
  logic             s_tready;
  logic [NC*DW-1:0] m_tdata;
  logic [NC-1:0]    m_tvalid;
  logic [NC-1:0]    m_tlast;
  logic [NC-1:0]    m_tready;
  logic             busy;
  logic             sel_err;
  logic [31:0]      pkt_count;

  // broadcast-disabled instance
  logic [NC-1:0]    z_sel;
  logic [DW-1:0]    z_tdata;
  logic             z_tvalid;
  logic             z_tlast;
  logic             z_s_tready;
  logic [NC*DW-1:0] z_m_tdata;
  logic [NC-1:0]    z_m_tvalid;
  logic [NC-1:0]    z_m_tlast;
  logic [NC-1:0]    z_m_tready;
  logic             z_busy;
  logic             z_sel_err;
  logic [31:0]      z_pkt_count;

  axis_channel_router #(.DATA_W(DW), .N_CH(NC), .BCAST_EN(1)) dut (
    .clk(clk), .rstn(rstn), .channel_select(sel),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .busy(busy), .sel_err(sel_err), .pkt_count(pkt_count)
  );

  axis_channel_router #(.DATA_W(DW), .N_CH(NC), .BCAST_EN(0)) dut_nb (
    .clk(clk), .rstn(rstn), .channel_select(z_sel),
    .s_axis_tdata(z_tdata), .s_axis_tvalid(z_tvalid), .s_axis_tlast(z_tlast),
    .s_axis_tready(z_s_tready),
    .m_axis_tdata(z_m_tdata), .m_axis_tvalid(z_m_tvalid), .m_axis_tlast(z_m_tlast),
    .m_axis_tready(z_m_tready),
    .busy(z_busy), .sel_err(z_sel_err), .pkt_count(z_pkt_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // per-channel handshake log of the broadcast-enabled instance
  int unsigned cnt [NC];
  int unsigned tlast_cnt [NC];
  logic [DW-1:0] last_data [NC];

  initial begin
    for (int i = 0; i < NC; i++) begin
      cnt[i] = 0;
      tlast_cnt[i] = 0;
      last_data[i] = '0;
    end
  end

  // Inputs only change just after posedge, so the negedge view decides
  // which handshakes complete at the next posedge.
  always @(negedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (m_tvalid[i] && m_tready[i]) begin
        cnt[i] = cnt[i] + 1;
        last_data[i] = m_tdata[i*DW +: DW];
        if (m_tlast[i]) tlast_cnt[i] = tlast_cnt[i] + 1;
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat, wait (bounded) for ready, let it be taken, drop valid.
  task automatic send_beat(input logic [DW-1:0] d, input logic last, output int stalls);
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    stalls   = 0;
    @(negedge clk);
    while (!s_tready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!s_tready) check_val("send_timeout", {63'd0, s_tready}, 64'd1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int tot;
    int sum;

    rstn = 1'b0;
    sel = '0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = '1;
    z_sel = '0; z_tdata = '0; z_tvalid = 1'b0; z_tlast = 1'b0; z_m_tready = '1;
    repeat (2) step();

    // ---- reset state
    @(negedge clk);
    check_val("rst_tready",  s_tready, 1'b0);
    check_val("rst_tvalid",  m_tvalid, 16'h0000);
    check_val("rst_tlast",   m_tlast, 16'h0000);
    check_val("rst_tdata0",  {63'd0, (m_tdata == '0)}, 64'd1);
    check_val("rst_busy",    busy, 1'b0);
    check_val("rst_sel_err", sel_err, 1'b0);
    check_val("rst_pkt_cnt", pkt_count, 32'd0);
    step();
    rstn = 1'b1;
    sel  = 16'h0004;
    step(); step();

    // ---- single channel, 4-beat packet into ch2, no bubbles
    tot = 0;
    send_beat(32'hA000_0000, 1'b0, st); tot += st;
    send_beat(32'hA000_0001, 1'b0, st); tot += st;
    send_beat(32'hA000_0002, 1'b0, st); tot += st;
    send_beat(32'hA000_0003, 1'b1, st); tot += st;
    @(negedge clk);
    check_val("t1_tvalid",   m_tvalid, 16'h0004);
    check_val("t1_tlast",    m_tlast, 16'h0004);
    check_val("t1_data_b3",  m_tdata[2*DW +: DW], 32'hA000_0003);
    check_val("t1_cnt_pre",  pkt_count, 32'd0);
    check_val("t1_busy",     busy, 1'b1);
    step();
    check_val("t1_stalls",   tot, 0);
    check_val("t1_ch2_cnt",  cnt[2], 4);
    sum = 0;
    for (int i = 0; i < NC; i++) sum += cnt[i];
    check_val("t1_tot_cnt",  sum, 4);
    check_val("t1_ch2_last", tlast_cnt[2], 1);
    check_val("t1_ch2_data", last_data[2], 32'hA000_0003);
    @(negedge clk);
    check_val("t1_pkt_cnt",  pkt_count, 32'd1);
    check_val("t1_idle_busy", busy, 1'b0);
    check_val("t1_idle_vld", m_tvalid, 16'h0000);
    step();

    // ---- select changes mid-packet: packet stays on ch2, next goes to ch4
    send_beat(32'hB000_0000, 1'b0, st);
    send_beat(32'hB000_0001, 1'b0, st);
    sel = 16'h0010;
    send_beat(32'hB000_0002, 1'b0, st);
    send_beat(32'hB000_0003, 1'b1, st);
    step(); step();
    send_beat(32'hC000_0000, 1'b1, st);
    step(); step();
    check_val("t2_ch2_cnt",  cnt[2], 8);
    check_val("t2_ch2_data", last_data[2], 32'hB000_0003);
    check_val("t2_ch4_cnt",  cnt[4], 1);
    check_val("t2_ch4_data", last_data[4], 32'hC000_0000);
    check_val("t2_pkt_cnt",  pkt_count, 32'd3);

    // ---- broadcast to ch0+ch1, ch1 not ready for 3 cycles
    sel = 16'h0003;
    m_tready = 16'hFFFD;
    step(); step();
    send_beat(32'hD000_0001, 1'b1, st);
    @(negedge clk);                        // t+1
    check_val("t3_vld_t1",   m_tvalid, 16'h0003);
    check_val("t3_rdy_t1",   s_tready, 1'b0);
    check_val("t3_ch1_data", m_tdata[1*DW +: DW], 32'hD000_0001);
    step(); @(negedge clk);                // t+2
    check_val("t3_vld_t2",   m_tvalid, 16'h0002);
    check_val("t3_rdy_t2",   s_tready, 1'b0);
    step(); @(negedge clk);                // t+3
    check_val("t3_rdy_t3",   s_tready, 1'b0);
    check_val("t3_busy_t3",  busy, 1'b1);
    step();                                // t+4
    m_tready = '1;
    @(negedge clk);
    check_val("t3_rdy_t4",   s_tready, 1'b1);
    check_val("t3_vld_t4",   m_tvalid, 16'h0002);
    check_val("t3_cnt_t4",   pkt_count, 32'd3);
    step(); @(negedge clk);
    check_val("t3_vld_t5",   m_tvalid, 16'h0000);
    check_val("t3_pkt_cnt",  pkt_count, 32'd4);
    step();
    check_val("t3_ch0_cnt",  cnt[0], 1);
    check_val("t3_ch1_cnt",  cnt[1], 1);
    check_val("t3_ch1_last", tlast_cnt[1], 1);
    check_val("t3_ch1_data", last_data[1], 32'hD000_0001);

    // ---- broadcast disabled: multi-hot select is rejected
    z_sel = 16'h0003;
    step(); step();
    z_tdata = 32'h5A5A_0001; z_tlast = 1'b1; z_tvalid = 1'b1;
    @(negedge clk);
    check_val("t4_sel_err",  z_sel_err, 1'b1);
    check_val("t4_tready",   z_s_tready, 1'b0);
    check_val("t4_tvalid",   z_m_tvalid, 16'h0000);
    step(); step(); @(negedge clk);
    check_val("t4_tready_h", z_s_tready, 1'b0);
    check_val("t4_busy",     z_busy, 1'b0);
    step();
    z_sel = 16'h0001;
    step();
    @(negedge clk);
    check_val("t4_err_clr",  z_sel_err, 1'b0);
    check_val("t4_resume",   z_s_tready, 1'b1);
    step();
    z_tvalid = 1'b0;
    @(negedge clk);
    check_val("t4_out_vld",  z_m_tvalid, 16'h0001);
    check_val("t4_out_data", z_m_tdata[0 +: DW], 32'h5A5A_0001);
    check_val("t4_out_last", z_m_tlast, 16'h0001);
    step(); @(negedge clk);
    check_val("t4_pkt_cnt",  z_pkt_count, 32'd1);
    step();

    // ---- zero select stalls the input indefinitely
    sel = 16'h0000;
    step(); step();
    s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = 32'hEEEE_EEEE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("t5_tready", s_tready, 1'b0);
      check_val("t5_tvalid", m_tvalid, 16'h0000);
      check_val("t5_busy",   busy, 1'b0);
      step();
    end
    s_tvalid = 1'b0;

    // ---- reset mid-packet, then route with the freshly sampled select
    sel = 16'h0008;
    step(); step();
    send_beat(32'hE000_0000, 1'b0, st);
    send_beat(32'hE000_0001, 1'b0, st);
    rstn = 1'b0;
    sel  = 16'h0020;
    step();
    rstn = 1'b1;
    @(negedge clk);
    check_val("t6_tready",   s_tready, 1'b0);
    check_val("t6_tvalid",   m_tvalid, 16'h0000);
    check_val("t6_tlast",    m_tlast, 16'h0000);
    check_val("t6_tdata0",   {63'd0, (m_tdata == '0)}, 64'd1);
    check_val("t6_busy",     busy, 1'b0);
    check_val("t6_sel_err",  sel_err, 1'b0);
    check_val("t6_pkt_cnt0", pkt_count, 32'd0);
    step(); step();
    check_val("t6_ch3_last", tlast_cnt[3], 0);
    send_beat(32'hF000_0000, 1'b1, st);
    step(); step();
    check_val("t6_ch5_cnt",  cnt[5], 1);
    check_val("t6_ch5_data", last_data[5], 32'hF000_0000);
    check_val("t6_pkt_cnt",  pkt_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
